// File: rtl/booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one booth_multiplier between
//            NREQ requesters. Accepts an operand pair from the winning
//            requester, pulses the multiplier start, times the multiply with a
//            fixed-latency counter (the multiplier has no done output), captures
//            the product and returns it tagged with the requester index.
// Ports    : clk, rst          - clock (rising edge), async active-high reset
//            req/req_m/req_q   - per-requester request level and packed operands
//            ack               - one-cycle pulse, operands of requester i taken
//            done              - one-cycle pulse, rsp_result valid for requester i
//            rsp_result/rsp_id - captured product and its owner, held between jobs
//            busy              - high whenever a job is in flight
//            mul_start/mul_m/mul_q/mul_result - booth_multiplier interface
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 5,
    parameter int RES_W   = 2*WIDTH-2,
    parameter int MUL_LAT = 6,
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_m,
    input  logic [NREQ*WIDTH-1:0] req_q,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       done,
    output logic [RES_W-1:0]      rsp_result,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_m,
    output logic [WIDTH-1:0]      mul_q,
    input  logic [RES_W-1:0]      mul_result
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [ID_W-1:0]  c_id_last  = ID_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any;
    logic [ID_W-1:0]  w_win;
    logic [WIDTH-1:0] w_m;
    logic [WIDTH-1:0] w_q;

    // Winner search: scan offsets from the highest down so that the lowest
    // offset from rr_ptr (i.e. the first set bit going upward, wrapping) wins.
    always_comb begin
        w_any = |req;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                w_win = ID_W'(idx);
            end
        end
        w_m = req_m[int'(w_win)*WIDTH +: WIDTH];
        w_q = req_q[int'(w_win)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_cnt      <= '0;
            ack        <= '0;
            done       <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
            busy       <= 1'b0;
            mul_start  <= 1'b0;
            mul_m      <= '0;
            mul_q      <= '0;
        end else begin
            // Pulse outputs default low; each state raises them for one cycle.
            ack       <= '0;
            done      <= '0;
            mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        mul_m       <= w_m;
                        mul_q       <= w_q;
                        ack[w_win]  <= 1'b1;
                        mul_start   <= 1'b1;
                        r_id        <= w_win;
                        r_cnt       <= c_cnt_load;
                        busy        <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Counter covers the multiplier latency measured from the
                    // edge where it samples start (one edge after acceptance).
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    rsp_result <= mul_result;
                    rsp_id     <= r_id;
                    done[r_id] <= 1'b1;
                    r_rr_ptr   <= (r_id == c_id_last) ? '0 : r_id + ID_W'(1);
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_arbiter
// Purpose  : Directed self-checking bench for booth_mult_arbiter, with a
//            behavioural fixed-latency multiplier whose result is only valid
//            on the exact capture edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 5;
    localparam int RES_W   = 8;
    localparam int MUL_LAT = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_m = '0;
    logic [NREQ*WIDTH-1:0] req_q = '0;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       done;
    logic [RES_W-1:0]      rsp_result;
    logic [1:0]            rsp_id;
    logic                  busy;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_m;
    logic [WIDTH-1:0]      mul_q;
    logic [RES_W-1:0]      mul_result;

    int n_tests = 0;
    int n_fail  = 0;
    int last_wait;

    booth_mult_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .RES_W   (RES_W),
        .MUL_LAT (MUL_LAT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_m      (req_m),
        .req_q      (req_q),
        .ack        (ack),
        .done       (done),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_m      (mul_m),
        .mul_q      (mul_q),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: product appears only on the edge MUL_LAT cycles after
    // start is sampled; any other time it shows a junk value.
    logic signed [2*WIDTH-1:0] m_prod;
    logic [RES_W-1:0]          m_hold;
    int                        m_cnt;
    assign m_prod     = $signed(mul_m) * $signed(mul_q);
    assign mul_result = (m_cnt == 1) ? m_hold : 8'h5A;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_hold <= '0;
        end else if (mul_start) begin
            m_hold <= m_prod[RES_W-1:0];
            m_cnt  <= MUL_LAT;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        req_m[i*WIDTH +: WIDTH] = m;
        req_q[i*WIDTH +: WIDTH] = q;
    endtask

    task automatic wait_ack();
        last_wait = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            last_wait++;
            if (ack != 0) break;
        end
        check("ack_seen", 32'(ack != 0), 1);
    endtask

    // Called in the ack cycle: checks acceptance, drops requests, then
    // follows the job to its done pulse.
    task automatic finish_job(input int win, input logic [WIDTH-1:0] em,
                              input logic [WIDTH-1:0] eq, input logic [RES_W-1:0] eres,
                              input logic [NREQ-1:0] drop_mask);
        int lat;
        int stray;
        check("ack_vec", ack, 32'(1) << win);
        check("mul_start", mul_start, 1);
        check("mul_m", mul_m, em);
        check("mul_q", mul_q, eq);
        check("busy_run", busy, 1);
        req = req & ~drop_mask;
        lat = 0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (ack != 0 || mul_start) stray++;
            if (done != 0) break;
        end
        check("latency", lat, MUL_LAT + 1);
        check("done_vec", done, 32'(1) << win);
        check("rsp_result", rsp_result, eres);
        check("rsp_id", rsp_id, win);
        check("busy_done", busy, 0);
        check("stray_ack_start", stray, 0);
        check("mul_m_stable", mul_m, em);
    endtask

    task automatic run_job(input int win, input logic [WIDTH-1:0] em,
                           input logic [WIDTH-1:0] eq, input logic [RES_W-1:0] eres,
                           input logic [NREQ-1:0] drop_mask);
        wait_ack();
        finish_job(win, em, eq, eres, drop_mask);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_m"}, mul_m, 0);
        check({tag, "_mul_q"}, mul_q, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] tm [NREQ];
        logic [WIDTH-1:0] tq [NREQ];
        logic [RES_W-1:0] tr [NREQ];
        int order [8];
        int early;
        int dcount;

        // Operand table: 3*-4=-12, -7*-9=63, -15*7=-105, 5*6=30
        tm[0] = 5'b00011; tq[0] = 5'b11100; tr[0] = 8'hF4;
        tm[1] = 5'b11001; tq[1] = 5'b10111; tr[1] = 8'h3F;
        tm[2] = 5'b10001; tq[2] = 5'b00111; tr[2] = 8'h97;
        tm[3] = 5'b00101; tq[3] = 5'b00110; tr[3] = 8'h1E;
        order = '{0, 2, 0, 2, 0, 2, 0, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single job, requester 0
        set_ops(0, tm[0], tq[0]);
        req[0] = 1'b1;
        run_job(0, tm[0], tq[0], 8'hF4, 4'b0001);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("rsp_hold", rsp_result, 8'hF4);
        check("idle_busy", busy, 0);

        // Sign/magnitude: -15*7, then 0*-9
        set_ops(2, tm[2], tq[2]);
        req[2] = 1'b1;
        run_job(2, tm[2], tq[2], 8'h97, 4'b0100);
        set_ops(1, 5'b00000, 5'b10111);
        req[1] = 1'b1;
        run_job(1, 5'b00000, 5'b10111, 8'h00, 4'b0010);

        // Simultaneous after reset: grants 0,1,2,3 back to back
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, tm[i], tq[i]);
        req = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            wait_ack();
            if (k > 0) check("simul_gap", last_wait, 1);
            finish_job(k, tm[k], tq[k], tr[k], 4'(1 << k));
        end

        // Fairness: 0 and 2 held, 1 rises after the seventh job
        req = 4'b0101;
        for (int j = 0; j < 8; j++) begin
            run_job(order[j], tm[order[j]], tq[order[j]], tr[order[j]],
                    (j == 7) ? 4'b1111 : 4'b0000);
            if (j == 6) req[1] = 1'b1;
        end

        // Reset mid-RUN: everything clears at once, no done for the aborted job
        req[2] = 1'b1;
        wait_ack();
        check("abort_ack", ack, 4'b0100);
        req[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrun_rst");
        dcount = 0;
        repeat (2) begin
            @(negedge clk);
            if (done != 0) dcount++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done != 0) dcount++;
        end
        check("abort_no_done", dcount, 0);
        req[3] = 1'b1;
        run_job(3, tm[3], tq[3], 8'h1E, 4'b1000);

        // Hold-while-busy: req[1] raised during job 0, operands changed while waiting
        req[0] = 1'b1;
        wait_ack();
        check("hold_ack0", ack, 4'b0001);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        set_ops(1, 5'b00010, 5'b00010);
        req[1] = 1'b1;
        @(negedge clk);
        set_ops(1, tm[1], tq[1]);
        early = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack != 0) early++;
            if (done != 0) break;
        end
        check("hold_no_early_ack", early, 0);
        check("hold_done0", done, 4'b0001);
        check("hold_result0", rsp_result, 8'hF4);
        wait_ack();
        check("hold_ack_after_done", last_wait, 1);
        finish_job(1, tm[1], tq[1], 8'h3F, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
